// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit: one bit per cycle (shift-add multiply,
// restoring divide), with single-cycle handling of divide-by-zero and signed overflow.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] srcA_i,
  input  logic [DATA_WIDTH-1:0] srcB_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, next_state;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            neg_q, rem_neg_q;
  logic [W-1:0]    operand;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    rem;

  logic            in_div, in_sa, in_sb, neg_a, neg_b;
  logic [W-1:0]    mag_a, mag_b;
  logic            div_zero, div_ovf, special, accept, last;
  logic [W-1:0]    special_result;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next, product, acc_next;
  logic [W:0]      shifted, diff;
  logic            q_bit;
  logic [W-1:0]    quo_next, rem_next, quotient, remainder, final_result;

  // Operand decode for the instruction currently presented in execute
  always_comb begin
    in_div   = op_i[2];
    in_sa    = in_div ? !op_i[0] : (op_i[1:0] != 2'b11);
    in_sb    = in_div ? !op_i[0] : !op_i[1];
    neg_a    = in_sa & srcA_i[W-1];
    neg_b    = in_sb & srcB_i[W-1];
    mag_a    = neg_a ? -srcA_i : srcA_i;
    mag_b    = neg_b ? -srcB_i : srcB_i;
    div_zero = in_div && (srcB_i == '0);
    div_ovf  = in_div && !op_i[0] && (srcA_i == {1'b1, {(W-1){1'b0}}}) && (srcB_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) special_result = op_i[1] ? srcA_i : '1;
    else          special_result = op_i[1] ? '0 : srcA_i;
  end

  // One iteration of each algorithm; the divider keeps its quotient in acc[W-1:0]
  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, operand} : '0);
    mul_next = {mul_sum, acc[W-1:1]};
    shifted  = {rem, acc[W-1]};
    diff     = shifted - {1'b0, operand};
    q_bit    = !diff[W];
    rem_next = q_bit ? diff[W-1:0] : shifted[W-1:0];
    quo_next = {acc[W-2:0], q_bit};
    acc_next = op_q[2] ? {acc[2*W-1:W], quo_next} : mul_next;

    product   = neg_q ? -mul_next : mul_next;
    quotient  = neg_q ? -quo_next : quo_next;
    remainder = rem_neg_q ? -rem_next : rem_next;
    case (op_q)
      3'b000:                 final_result = product[W-1:0];
      3'b001, 3'b010, 3'b011: final_result = product[2*W-1:W];
      3'b100, 3'b101:         final_result = quotient;
      default:                final_result = remainder;
    endcase
  end

  assign last   = (count == CW'(W - 1));
  assign accept = start_i && !flush_i && (state != BUSY);
  assign done_o = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy_o     = 1'b0;
    case (state)
      BUSY: begin
        busy_o = 1'b1;
        if (last) next_state = DONE;
      end
      default: begin
        busy_o = start_i & !special;
        if (start_i) next_state = special ? DONE : BUSY;
        else         next_state = IDLE;
      end
    endcase
    if (flush_i) next_state = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      operand   <= '0;
      acc       <= '0;
      rem       <= '0;
      result_o  <= '0;
    end else if (!flush_i) begin
      if (accept) begin
        count     <= '0;
        op_q      <= op_i;
        neg_q     <= neg_a ^ neg_b;
        rem_neg_q <= neg_a;
        operand   <= in_div ? mag_b : mag_a;
        acc       <= {{W{1'b0}}, (in_div ? mag_a : mag_b)};
        rem       <= '0;
        if (special) result_o <= special_result;
      end else if (state == BUSY) begin
        count <= count + CW'(1);
        acc   <= acc_next;
        rem   <= rem_next;
        if (last) result_o <= final_result;
      end
    end
  end

endmodule
